// File: rtl/mult_32bit_seq.sv
// Unsigned WIDTHxWIDTH shift-add multiplier: one product bit per cycle; result valid 32 edges after start accept.
// start is ignored while busy; DONE accepts a new start for back-to-back throughput of one op per 33 cycles.
module mult_32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // Add is W+1 wide so the carry lands in acc[W] before the joint shift.
    sum      = mplier_q[0] ? ({1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q}) : acc_q;
    shifted  = {sum, mplier_q} >> 1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = value1;
          mplier_d = value2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = shifted[2*WIDTH:WIDTH];
        mplier_d = shifted[WIDTH-1:0];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          hi_d    = shifted[2*WIDTH-1:WIDTH];
          lo_d    = shifted[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_32bit_seq.sv
// Directed bench for mult_32bit_seq: hand-computed products, latency, hold, back-to-back and reset abort.
module tb_mult_32bit_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] value1;
  logic [31:0] value2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  mult_32bit_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .value1  (value1),
    .value2  (value2),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; start is held across exactly one rising edge, then operands are scrambled.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    value1 = a;
    value2 = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    value1 = 32'hDEADBEEF;
    value2 = 32'hCAFEF00D;
  endtask

  // Waits (bounded) for done; reports edges since accept, busy cycles, and hi/lo changes before done.
  task automatic wait_done(input logic glitch, output int edges, output int busy_cycles,
                           output int hold_bad);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    hold_bad    = 0;
    edges       = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
      if (busy === 1'b1) busy_cycles++;
      if (done !== 1'b1 && (hi !== last_hi || lo !== last_lo)) hold_bad++;
      if (glitch && edges == 5) begin
        value1 = 32'h00001234;
        value2 = 32'h00005678;
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    value1  = 32'h0;
    value2  = 32'h0;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_product(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int edges, bc, hb;
    @(negedge clk);
    issue(a, b);
    wait_done(1'b0, edges, bc, hb);
    checks++;
    if (edges !== 32) begin
      errors++;
      $display("FAIL %s_latency: done after %0d edges, required 32", name, edges);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_product: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("FAIL %s_busy: busy for %0d cycles, required 33", name, bc);
    end
    checks++;
    if (hb !== 0) begin
      errors++;
      $display("FAIL %s_hold: hi/lo changed %0d times during RUN, required 0", name, hb);
    end
    last_hi = exp_hi;
    last_lo = exp_lo;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: after DONE done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_isolation();
    int edges, bc, hb;
    @(negedge clk);
    issue(32'h0000FFFF, 32'h0000FFFF);
    wait_done(1'b1, edges, bc, hb);
    checks++;
    if (edges !== 32) begin
      errors++;
      $display("FAIL isolation_latency: done after %0d edges, required 32", edges);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL isolation_product: hi=%h lo=%h, required hi=00000000 lo=fffe0001", hi, lo);
    end
    checks++;
    if (hb !== 0) begin
      errors++;
      $display("FAIL isolation_hold: hi/lo changed %0d times during RUN, required 0", hb);
    end
    last_hi = 32'h0;
    last_lo = 32'hFFFE0001;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL isolation_restart: busy=%b done=%b after op, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int edges, bc, hb;
    @(negedge clk);
    issue(32'h12345678, 32'h00000010);
    wait_done(1'b0, edges, bc, hb);
    checks++;
    if (edges !== 32 || hi !== 32'h1 || lo !== 32'h23456780) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d hi=%h lo=%h, required 32 00000001 23456780", edges, hi, lo);
    end
    last_hi = 32'h1;
    last_lo = 32'h23456780;
    issue(32'h0, 32'h12345678);
    wait_done(1'b0, edges, bc, hb);
    checks++;
    if (edges + 1 !== 33) begin
      errors++;
      $display("FAIL b2b_spacing: second done %0d cycles after first, required 33", edges + 1);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second: hi=%h lo=%h, required 0 0", hi, lo);
    end
    checks++;
    if (hb !== 0) begin
      errors++;
      $display("FAIL b2b_window: first result disturbed %0d times, required 0", hb);
    end
    last_hi = 32'h0;
    last_lo = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int edges, bc, hb, seen;
    // Make the visible result non-zero so the reset clear is observable.
    test_product("pre_abort", 32'h00000010, 32'h00000010, 32'h0, 32'h00000100);
    @(negedge clk);
    issue(32'd7, 32'd9);
    repeat (9) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: busy/done seen %0d cycles after abort, required 0", seen);
    end
    last_hi = 32'h0;
    last_lo = 32'h0;
    issue(32'd7, 32'd9);
    wait_done(1'b0, edges, bc, hb);
    checks++;
    if (edges !== 32 || hi !== 32'h0 || lo !== 32'h0000003F) begin
      errors++;
      $display("FAIL abort_rerun: edges=%0d hi=%h lo=%h, required 32 00000000 0000003f", edges, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_product("basic", 32'd3, 32'd5, 32'h0, 32'h0000000F);
    test_product("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    test_product("alt_bits", 32'hAAAAAAAA, 32'h00000002, 32'h00000001, 32'h55555554);
    test_product("half_word", 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    test_isolation();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_32bit_seq.md
# mult_32bit_seq

Multi-cycle unsigned 32x32 shift-add multiplier in the MiniMIPS ALU execution stage. It takes the same two 32-bit operand buses (`value1`, `value2`) that drive the combinational bitwise units such as `and_32bit`. It produces a 64-bit product split into `hi`/`lo` registers for the MULTU path. A start/busy/done handshake lets the control FSM stall the pipeline while the iteration runs.

## Interface
- `WIDTH`, 32, operand width; the product is 2*WIDTH bits. Only 32 is verified.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a multiply; sampled on the rising edge
- `value1`  in  32  multiplicand, unsigned; sampled only when `start` is accepted
- `value2`  in  32  multiplier, unsigned; sampled only when `start` is accepted
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse when `hi`/`lo` have just been updated
- `hi`  out  32  product bits [63:32]
- `lo`  out  32  product bits [31:0]

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On `start`=1: latch `value1` into `mcand`, latch `value2` into `mplier`, clear the 33-bit accumulator `acc`, set `cnt`=0, go to RUN.
  - Otherwise stay in IDLE.
- **RUN** (one iteration per cycle)
  - If `mplier[0]`=1: `acc` = `acc[31:0]` + `mcand`, computed 33 bits wide to keep the carry.
  - Then shift the 65-bit value {`acc`, `mplier`} right by 1. `mplier` becomes the low product half.
  - `cnt` increments each cycle. When `cnt`=WIDTH-1, this is the last iteration: go to DONE and load `hi`=final `acc[31:0]`, `lo`=final `mplier`.
- **DONE**
  - `done`=1 for this single cycle.
  - If `start`=1 in this cycle, it is accepted exactly as in IDLE (back-to-back operation) and the FSM goes to RUN; otherwise it goes to IDLE.
- `start` in RUN is ignored: no relatch, no restart, no error.
- Operands are internally registered. `value1`/`value2` may change freely after the accepting edge.
- `hi`/`lo` change only on entry to DONE. They hold the previous result for the whole of RUN.
- Arithmetic is unsigned only: no sign handling and no overflow flag. The full 64-bit product is always exact.

## Timing
- Reset (asynchronous, `reset_n`=0): state=IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; `acc`, `cnt`, `mcand`, `mplier` all cleared.
- Reset takes effect immediately, independent of `clk`.
- Reset mid-RUN aborts the operation. No `done` is produced, and `hi`/`lo` read 0 after reset.
- First rising edge with `reset_n`=1 is normal operation.
- Let edge E0 be the edge that accepts `start`.
  - `busy`=1 from after E0 through the DONE cycle inclusive.
  - RUN lasts WIDTH=32 cycles (edges E1..E32).
  - Edge E32 enters DONE, so `done`=1 and the new `hi`/`lo` are valid in the cycle after E32.
  - Latency from accepting edge to result: 32 edges.
- `busy` is a registered output: it is 1 in RUN and DONE, 0 in IDLE.
- `done` is a registered output: it is 1 only in DONE.
- Back-to-back: `start` held high continuously yields `done` every 33 cycles.
- Throughput is one operation per 33 cycles.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-cycle with no clock edge -> `busy`=0, `done`=0, `hi`=0, `lo`=0 immediately.
- **Basic products:** `value1`=3, `value2`=5, pulse `start` -> `done` exactly 32 edges after the accepting edge; `hi`=0x00000000, `lo`=0x0000000F; `busy` high for 33 cycles.
- **Carry path:**
  - 0xFFFFFFFF x 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - 0xAAAAAAAA x 0x00000002 -> `hi`=0x00000001, `lo`=0x55555554.
  - 0x00010000 x 0x00010000 -> `hi`=0x00000001, `lo`=0x00000000.
- **Operand isolation:**
  - Start 0x0000FFFF x 0x0000FFFF, then change the operands and pulse `start` during RUN -> start ignored; result `hi`=0, `lo`=0xFFFE0001.
  - During RUN, `hi`/`lo` keep the prior result.
- **Back-to-back:** assert `start` in the DONE cycle with 0 x 0x12345678 -> second `done` 33 cycles after the first, with `hi`=0 and `lo`=0; the first result was visible for exactly that window.
- **Reset mid-operation:** pulse `reset_n` low at iteration 10 of 7 x 9 -> no `done`, `hi`=`lo`=0. A new start of 7 x 9 afterwards gives `lo`=0x0000003F on schedule.
